// File: rtl/alu_op_sequencer_if.sv
// Instruction, RAM and ALU signal bundle between the sequencer (slave) and its surroundings (master).
interface alu_op_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [19:0] instr;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_cout;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic        carry_flag;

    modport master (
        output instr_valid, instr, ram_rdata, alu_out, alu_cout,
        input  instr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               alu_a, alu_b, alu_sel, done, illegal, zero_flag, carry_flag
    );

    modport slave (
        input  instr_valid, instr, ram_rdata, alu_out, alu_cout,
        output instr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               alu_a, alu_b, alu_sel, done, illegal, zero_flag, carry_flag
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one 20-bit data-path instruction over a 16x8 RAM and external ALU.
// Optional macro ALU_SEQ_BYPASS_EN: single RAM read when both sources of a binary op share an address.
module alu_op_sequencer #(
    parameter int RAM_RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WB, RET
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(RAM_RD_LAT - 1);

    state_t     r_state;
    logic       r_ready;
    logic [3:0] r_op;
    logic [3:0] r_dst;
    logic [3:0] r_arg2;
    logic [3:0] r_arg3;
    logic [1:0] r_wait_cnt;
    logic       r_ram_en;
    logic       r_ram_we;
    logic [3:0] r_ram_addr;
    logic [7:0] r_ram_wdata;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_sel;
    logic       r_done;
    logic       r_illegal;
    logic       r_zero;
    logic       r_carry;

    logic       w_accept;
    logic [3:0] w_op;
    logic       w_binary;
    logic       w_bypass;
    logic       w_flag_op;
    logic       w_carry_op;
    logic [7:0] w_result;

    assign w_accept   = bus.instr_valid && r_ready;
    assign w_op       = bus.instr[19:16];
    assign w_binary   = ((r_op >= 4'h1) && (r_op <= 4'h5)) || (r_op == 4'hB);
    assign w_flag_op  = (r_op >= 4'h1) && (r_op <= 4'h6);
    assign w_carry_op = (r_op == 4'h1) || (r_op == 4'h2);

`ifdef ALU_SEQ_BYPASS_EN
    assign w_bypass = w_binary && (r_arg3 == r_arg2);
`else
    assign w_bypass = 1'b0;
`endif

    // CMP reuses XOR: equal operands give zero. Shifts of 8 or more flush to zero.
    always_comb begin
        w_result = bus.alu_out;
        case (r_op)
            4'hB:    w_result = (bus.alu_out == 8'h00) ? 8'h01 : 8'h00;
            4'hD:    w_result = r_arg3[3] ? 8'h00 : (r_alu_a << r_arg3[2:0]);
            4'hE:    w_result = r_arg3[3] ? 8'h00 : (r_alu_a >> r_arg3[2:0]);
            default: w_result = bus.alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_op        <= 4'h0;
            r_dst       <= 4'h0;
            r_arg2      <= 4'h0;
            r_arg3      <= 4'h0;
            r_wait_cnt  <= 2'd0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 4'h0;
            r_ram_wdata <= 8'h00;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_sel   <= 4'h0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_ram_en  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_op    <= w_op;
                        r_dst   <= bus.instr[11:8];
                        r_arg2  <= bus.instr[7:4];
                        r_arg3  <= bus.instr[3:0];
                        case (w_op)
                            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB, 4'hD, 4'hE: begin
                                if (w_op == 4'hB)
                                    r_alu_sel <= 4'h5;
                                else if (w_op <= 4'h6)
                                    r_alu_sel <= w_op;
                                r_ram_en   <= 1'b1;
                                r_ram_addr <= bus.instr[7:4];
                                r_state    <= RD_A;
                            end
                            4'h7: begin
                                r_ram_en    <= 1'b1;
                                r_ram_we    <= 1'b1;
                                r_ram_addr  <= bus.instr[7:4];
                                r_ram_wdata <= bus.instr[15:8];
                                r_done      <= 1'b1;
                                r_state     <= WB;
                            end
                            4'hC: begin
                                r_done  <= 1'b1;
                                r_state <= RET;
                            end
                            default: begin
                                r_done    <= 1'b1;
                                r_illegal <= 1'b1;
                                r_state   <= RET;
                            end
                        endcase
                    end
                end
                RD_A: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= WAIT_A;
                end
                WAIT_A: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_alu_a <= bus.ram_rdata;
                        if (w_bypass) begin
                            r_alu_b <= bus.ram_rdata;
                            r_state <= EXEC;
                        end else if (w_binary) begin
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= r_arg3;
                            r_state    <= RD_B;
                        end else begin
                            r_state <= EXEC;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                RD_B: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= WAIT_B;
                end
                WAIT_B: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_alu_b <= bus.ram_rdata;
                        r_state <= EXEC;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                EXEC: begin
                    if (w_flag_op)
                        r_zero <= (bus.alu_out == 8'h00);
                    if (w_carry_op)
                        r_carry <= bus.alu_cout;
                    r_ram_en    <= 1'b1;
                    r_ram_we    <= 1'b1;
                    r_ram_addr  <= r_dst;
                    r_ram_wdata <= w_result;
                    r_done      <= 1'b1;
                    r_state     <= WB;
                end
                WB, RET: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.ram_en      = r_ram_en;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
    assign bus.zero_flag   = r_zero;
    assign bus.carry_flag  = r_carry;

endmodule
